fetch_unit: RTL

//   Instruction-fetch stage directly upstream of the single-cycle datapath.

---
 rtl/fetch_unit_pkg.sv | 25 ++
 rtl/fetch_unit_if.sv | 38 +++
 rtl/fetch_unit_queue.sv | 76 +++++++
 rtl/fetch_unit.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_pkg
//  Purpose  : Shared constants and FSM encodings for the instruction-fetch
//             stage (queue depth, bus widths, PC step, fetch states).
//  Revision : 1.0  initial release
// ============================================================================
package fetch_unit_pkg;

  // Default geometry of the fetch stage
  localparam int unsigned c_qdepth = 4;
  localparam int unsigned c_aw     = 32;
  localparam int unsigned c_dw     = 32;

  // Byte distance between consecutive instruction words
  localparam int unsigned c_pc_inc = 4;

  // Fetch FSM encoding
  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t c_fetch_idle    = 2'd0;
  localparam fetch_state_t c_fetch_fetch   = 2'd1;
  localparam fetch_state_t c_fetch_discard = 2'd2;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit_if
//  Purpose  : Bundles the instruction-memory req/ack port, the redirect
//             input and the decode valid/ready port of the fetch stage.
//             master = fetch stage, slave = memory/decode/branch side.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int unsigned AW = c_aw,
  parameter int unsigned DW = c_dw
) ();

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, redirect, redirect_pc, instr_ready
  );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_queue
//  Purpose  : Circular FIFO of {pc, instruction} pairs between instruction
//             memory and decode. Flush empties it in one cycle; the head is
//             read straight from storage (no write-through bypass).
//  Revision : 1.0  initial release
// ============================================================================
module fetch_queue #(
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned AW    = 32,
  parameter  int unsigned DW    = 32,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          i_push,
  input  wire logic [AW-1:0] i_push_pc,
  input  wire logic [DW-1:0] i_push_instr,
  input  wire logic          i_pop,
  input  wire logic          i_flush,
  output logic      [AW-1:0] o_head_pc,
  output logic      [DW-1:0] o_head_instr,
  output logic      [CW-1:0] o_count,
  output logic               o_empty,
  output logic               o_full
);

  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [AW-1:0] r_pc_mem    [DEPTH];
  logic [DW-1:0] r_instr_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty      = (r_count == '0);
  assign o_full       = (r_count == c_depth);
  assign o_count      = r_count;
  assign o_head_pc    = r_pc_mem[r_rd_ptr];
  assign o_head_instr = r_instr_mem[r_rd_ptr];

  // Overflow/underflow guards keep the pointers coherent even if misused
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents need no reset because occupancy gates their use
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_pc_mem[r_wr_ptr]    <= i_push_pc;
      r_instr_mem[r_wr_ptr] <= i_push_instr;
    end
  end

endmodule : fetch_queue
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction-fetch stage. Owns the fetch PC, keeps at most one
//             request outstanding to instruction memory, buffers returned
//             words with their PCs, and hands them to decode over a
//             valid/ready port. A redirect flushes everything fetched so far;
//             if a request is still in flight its data is dropped on arrival.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned QDEPTH = c_qdepth,
  parameter int unsigned AW     = c_aw,
  parameter int unsigned DW     = c_dw
) (
  input  wire logic          CLK,
  input  wire logic          Reset,
  input  wire logic [AW-1:0] startPC,
  fetch_unit_if.master       bus
);

  localparam int unsigned   CW           = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] c_qdepth_cnt = CW'(QDEPTH);
  localparam logic [AW-1:0] c_align_mask = ~AW'(3);
  localparam logic [AW-1:0] c_pc_step    = AW'(c_pc_inc);

  fetch_state_t  r_state;
  fetch_state_t  w_state_next;
  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] w_fetch_pc_next;
  logic [AW-1:0] r_pending_pc;
  logic [AW-1:0] w_pending_pc_next;
  logic [AW-1:0] w_redirect_pc;

  logic          w_redirect;
  logic          w_req;
  logic          w_ack;
  logic          w_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_flush;
  logic [CW-1:0] w_count_next;

  logic [AW-1:0] w_head_pc;
  logic [DW-1:0] w_head_instr;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;

  fetch_queue #(
    .DEPTH (QDEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_queue (
    .clk          (CLK),
    .rst          (Reset),
    .i_push       (w_push),
    .i_push_pc    (r_fetch_pc),
    .i_push_instr (bus.imem_rdata),
    .i_pop        (w_pop),
    .i_flush      (w_flush),
    .o_head_pc    (w_head_pc),
    .o_head_instr (w_head_instr),
    .o_count      (w_count),
    .o_empty      (w_empty),
    .o_full       (w_full)
  );

  // Low PC bits are forced to zero; masking keeps every input bit in use
  assign w_redirect_pc = bus.redirect_pc & c_align_mask;

  assign bus.imem_req    = w_req;
  assign bus.imem_addr   = r_fetch_pc;
  assign bus.instr_valid = w_valid;
  assign bus.instr       = w_valid ? w_head_instr : '0;
  assign bus.instr_pc    = w_valid ? w_head_pc : '0;

  // State register plus fetch/pending PCs; reset reloads startPC every cycle
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state      <= c_fetch_fetch;
      r_fetch_pc   <= startPC & c_align_mask;
      r_pending_pc <= '0;
    end else begin
      r_state      <= w_state_next;
      r_fetch_pc   <= w_fetch_pc_next;
      r_pending_pc <= w_pending_pc_next;
    end
  end

  // Handshake decode: request, accepted ack, queue push/pop/flush
  always_comb begin
    w_redirect = bus.redirect & ~Reset;
    w_req      = ~Reset & ((r_state == c_fetch_fetch) || (r_state == c_fetch_discard));
    w_ack      = w_req & bus.imem_ack;
    w_valid    = ~Reset & ~w_empty;
    // Only a live FETCH ack delivers data; DISCARD acks belong to a dead path
    w_push     = (r_state == c_fetch_fetch) & w_ack & ~w_redirect;
    // Redirect beats pop so the queue is empty the cycle after a redirect
    w_pop      = w_valid & bus.instr_ready & ~w_redirect;
    w_flush    = w_redirect;
  end

  // Next state and next PCs
  always_comb begin
    w_state_next      = r_state;
    w_fetch_pc_next   = r_fetch_pc;
    w_pending_pc_next = r_pending_pc;
    w_count_next      = w_count + {{(CW-1){1'b0}}, w_push} - {{(CW-1){1'b0}}, w_pop};

    case (r_state)
      c_fetch_idle: begin
        if (w_redirect) begin
          w_fetch_pc_next = w_redirect_pc;
          w_state_next    = c_fetch_fetch;
        end else if (!w_full || w_pop) begin
          // Room appears after this cycle's pop: resume requesting
          w_state_next = c_fetch_fetch;
        end
      end

      c_fetch_fetch: begin
        if (w_redirect) begin
          if (w_ack) begin
            w_fetch_pc_next = w_redirect_pc;
          end else begin
            // Keep the in-flight address stable and park the new target
            w_pending_pc_next = w_redirect_pc;
            w_state_next      = c_fetch_discard;
          end
        end else if (w_ack) begin
          w_fetch_pc_next = r_fetch_pc + c_pc_step;
          if (w_count_next == c_qdepth_cnt) w_state_next = c_fetch_idle;
        end
      end

      c_fetch_discard: begin
        if (w_ack) begin
          w_fetch_pc_next = w_redirect ? w_redirect_pc : r_pending_pc;
          w_state_next    = c_fetch_fetch;
        end else if (w_redirect) begin
          w_pending_pc_next = w_redirect_pc;
        end
      end

      default: w_state_next = c_fetch_fetch;
    endcase
  end

endmodule : fetch_unit
`default_nettype wire
